// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter: requester count,
// FSM state encoding and hold counter width.
package arb_pkg;

  localparam int NREQ   = 4;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    TURN  = 2'b10
  } arb_state_e;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first requester found scanning from ptr
// upward, modulo 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            valid,
  output logic [1:0]      idx
);

  logic [1:0] cand;

  // Scan from farthest to nearest so the entry closest to ptr wins last.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Four-requester round-robin bus arbiter with registered one-hot grant, a
// one-cycle bus turnaround and a pulled-down shared data bus.
// Define ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module rr_bus_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] done,
  input  logic [NREQ-1:0] i,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      sel,
  output logic            busy,
  output logic            out,
  output logic            timeout
);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] req_q;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      ptr_q, ptr_d;
  logic            timeout_q, timeout_d;
  logic            pick_valid;
  logic [1:0]      pick_idx;
  logic            owner_release;

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
`else
  localparam int HOLD_MAX_UNUSED = HOLD_MAX;
`endif

  // Arbitration sees the registered request, adding one cycle of grant latency.
  rr_pick4 u_pick (
    .req   (req_q),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_release = done[sel_q] | ~req[sel_q];

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      IDLE, TURN: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = onehot4(pick_idx);
          sel_d   = pick_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (owner_release) begin
          state_d = TURN;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end
`ifdef ARB_TIMEOUT_EN
        // A normal release in the last allowed cycle wins over the forced one.
        else if (hold_q == HOLD_LAST) begin
          state_d   = TURN;
          gnt_d     = '0;
          ptr_d     = sel_q + 2'd1;
          timeout_d = 1'b1;
        end
        if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      req_q     <= '0;
      sel_q     <= 2'd0;
      ptr_q     <= 2'd0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      req_q     <= req;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = |gnt_q;
  assign out     = busy ? i[sel_q] : 1'b0;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Directed testbench for rr_bus_arbiter4; checks reset, latency, round-robin
// order, non-owner isolation, hold limit and mid-grant reset.
module tb_rr_bus_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] i;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       out;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter4 #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .i       (i),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .out     (out),
    .timeout (timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    i    = 4'b0000;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_checks++;
    if (sel !== 2'd0) begin n_errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b0 || out !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags got busy=%b timeout=%b out=%b exp=0 0 0", busy, timeout, out);
    end
  endtask

  task automatic test_basic_grant();
    do_reset();
    req = 4'b0100;
    i   = 4'b0101;
    step();
    n_checks++;
    if (gnt !== 4'b0000) begin n_errors++; $display("FAIL latency_edge1 got=%b exp=0000", gnt); end
    step();
    n_checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
      n_errors++; $display("FAIL basic_grant got gnt=%b sel=%0d busy=%b exp 0100 2 1", gnt, sel, busy);
    end
    n_checks++;
    if (out !== 1'b1) begin n_errors++; $display("FAIL basic_out_hi got=%b exp=1", out); end
    i = 4'b1011;
    #1;
    n_checks++;
    if (out !== 1'b0) begin n_errors++; $display("FAIL basic_out_lo got=%b exp=0", out); end
    req = 4'b0000;
    i   = 4'b1111;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd2 || out !== 1'b0) begin
      n_errors++; $display("FAIL basic_turn got gnt=%b sel=%0d out=%b exp 0000 2 0", gnt, sel, out);
    end
    step();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd2) begin
      n_errors++; $display("FAIL basic_idle got gnt=%b sel=%0d exp 0000 2", gnt, sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    int owners[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << owners[k];
      n_checks++;
      if (gnt !== exp_g || sel !== 2'(owners[k])) begin
        n_errors++; $display("FAIL rr_grant%0d_c1 got gnt=%b sel=%0d exp %b %0d", k, gnt, sel, exp_g, owners[k]);
      end
      step();
      n_checks++;
      if (gnt !== exp_g) begin n_errors++; $display("FAIL rr_grant%0d_c2 got=%b exp=%b", k, gnt, exp_g); end
      done = exp_g;
      step();
      done = 4'b0000;
      n_checks++;
      if (gnt !== 4'b0000) begin n_errors++; $display("FAIL rr_gap%0d got=%b exp=0000", k, gnt); end
      step();
    end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_nonowner_done();
    do_reset();
    req = 4'b0010;
    step();
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin n_errors++; $display("FAIL no_setup got=%b exp=0010", gnt); end
    req  = 4'b0011;
    done = 4'b0001;
    step();
    done = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0010) begin n_errors++; $display("FAIL no_ignore_done0 got=%b exp=0010", gnt); end
    done = 4'b0010;
    step();
    done = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0000) begin n_errors++; $display("FAIL no_turn got=%b exp=0000", gnt); end
    step();
    n_checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_errors++; $display("FAIL no_next got gnt=%b sel=%0d exp 0001 0", gnt, sel);
    end
    done = 4'b0001;
    step();
    done = 4'b0000;
    step();
    n_checks++;
    if (gnt !== 4'b0010) begin n_errors++; $display("FAIL no_ptr_wrap got=%b exp=0010", gnt); end
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_hold_limit();
    do_reset();
    req = 4'b1000;
    step();
    step();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (gnt !== 4'b1000 || timeout !== 1'b0) begin
        n_errors++; $display("FAIL to_hold_c%0d got gnt=%b timeout=%b exp 1000 0", c, gnt, timeout);
      end
      step();
    end
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_errors++; $display("FAIL to_forced got gnt=%b timeout=%b exp 0000 1", gnt, timeout);
    end
    step();
    n_checks++;
    if (gnt !== 4'b1000 || timeout !== 1'b0) begin
      n_errors++; $display("FAIL to_regrant got gnt=%b timeout=%b exp 1000 0", gnt, timeout);
    end
    step();
    step();
    step();
    done = 4'b1000;
    step();
    done = 4'b0000;
    n_checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_errors++; $display("FAIL to_release_wins got gnt=%b timeout=%b exp 0000 0", gnt, timeout);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      n_checks++;
      if (gnt !== 4'b1000 || timeout !== 1'b0) begin
        n_errors++; $display("FAIL hold_persist_c%0d got gnt=%b timeout=%b exp 1000 0", c, gnt, timeout);
      end
      step();
    end
`endif
    req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1000;
    step();
    step();
    n_checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_errors++; $display("FAIL rm_setup got gnt=%b sel=%0d exp 1000 3", gnt, sel);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL rm_cleared got gnt=%b sel=%0d busy=%b exp 0000 0 0", gnt, sel, busy);
    end
    rst = 1'b0;
    req = 4'b1010;
    step();
    n_checks++;
    if (gnt !== 4'b0000) begin n_errors++; $display("FAIL rm_latency got=%b exp=0000", gnt); end
    step();
    n_checks++;
    if (gnt !== 4'b0010 || sel !== 2'd1) begin
      n_errors++; $display("FAIL rm_first_owner got gnt=%b sel=%0d exp 0010 1", gnt, sel);
    end
    req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_round_robin();
    test_nonowner_done();
    test_hold_limit();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
